// File: rtl/serial_mux_pkg.sv
// Shared definitions for the multi-serial bus MUX: arbiter states, frame header
// layout and the priority-width helper.
package serial_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Header byte: LEN [7:4], reserved [3] (always 0), CHAN [2:0]
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 4;
  localparam int HDR_RSVD_BIT = 3;
  localparam int HDR_CHAN_MSB = 2;
  localparam int HDR_CHAN_LSB = 0;
  localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int HDR_CHAN_W   = HDR_CHAN_MSB - HDR_CHAN_LSB + 1;

  function automatic int prio_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

  function automatic logic [7:0] build_header(input logic [HDR_LEN_W-1:0]  len,
                                              input logic [HDR_CHAN_W-1:0] chan);
    logic [7:0] hdr;
    hdr                            = '0;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_RSVD_BIT]              = 1'b0;
    hdr[HDR_CHAN_MSB:HDR_CHAN_LSB] = chan;
    return hdr;
  endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational highest-priority winner search; the scan starts at rr_base so
// that ties resolve to the first equal-priority channel at or after the base.
module prio_select
  import serial_mux_pkg::*;
#(
  parameter int N_CHAN = 8,
  parameter int PRIO_W = 3
) (
  input  logic [N_CHAN*PRIO_W-1:0] prio,
  input  logic [HDR_CHAN_W-1:0]    rr_base,
  output logic [HDR_CHAN_W-1:0]    win_idx,
  output logic                     any_req
);

  logic [PRIO_W-1:0] best;

  always_comb begin
    int idx;
    best    = '0;
    win_idx = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      idx = int'(rr_base) + k;
      if (idx >= N_CHAN) idx = idx - N_CHAN;
      // Strictly greater keeps the earliest channel in scan order on a tie
      if (prio[idx*PRIO_W +: PRIO_W] > best) begin
        best    = prio[idx*PRIO_W +: PRIO_W];
        win_idx = HDR_CHAN_W'(idx);
      end
    end
    any_req = (best != '0);
  end

endmodule

// File: rtl/serial_chan_arbiter.sv
// Arbitrates N_CHAN RS232 RX channels and emits header+burst frames to the host.
// Define SERIAL_ARB_RR_FAIRNESS_EN for round-robin tie-break; default is lowest index.
module serial_chan_arbiter
  import serial_mux_pkg::*;
#(
  parameter  int D_W             = 8,
  parameter  int N_CHAN          = 8,
  parameter  int PRIORITY_LEVELS = 8,
  parameter  int BURST_MAX       = 4,
  localparam int PRIO_W          = prio_width(PRIORITY_LEVELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CHAN*PRIO_W-1:0] chan_priority_rx,
  input  logic [N_CHAN*D_W-1:0]    chan_data_out,
  output logic [N_CHAN-1:0]        chan_commit_read,
  output logic [N_CHAN-1:0]        chan_active,
  output logic [D_W-1:0]           host_data,
  output logic                     host_valid,
  input  logic                     host_ready,
  output logic                     host_last
);

  arb_state_e             state_q, state_d;
  logic [HDR_CHAN_W-1:0]  grant_q, grant_d;
  logic [HDR_LEN_W-1:0]   len_q, len_d;
  logic [HDR_LEN_W-1:0]   remaining_q, remaining_d;
  logic [D_W-1:0]         host_data_q, host_data_d;
  logic                   host_valid_q, host_valid_d;
  logic                   host_last_q, host_last_d;
  logic [N_CHAN-1:0]      chan_active_q, chan_active_d;

  logic [HDR_CHAN_W-1:0]  rr_base;
  logic [HDR_CHAN_W-1:0]  win_idx;
  logic                   any_req;
  logic [PRIO_W-1:0]      win_prio;
  logic [HDR_LEN_W-1:0]   win_len;
  logic [D_W-1:0]         head_byte;
  logic                   accept;
  logic                   pop_fire;

`ifdef SERIAL_ARB_RR_FAIRNESS_EN
  logic [HDR_CHAN_W-1:0]  rr_ptr_q, rr_ptr_d;
  assign rr_base = rr_ptr_q;
`else
  assign rr_base = '0;
`endif

  prio_select #(
    .N_CHAN (N_CHAN),
    .PRIO_W (PRIO_W)
  ) u_prio_select (
    .prio    (chan_priority_rx),
    .rr_base (rr_base),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  assign win_prio  = chan_priority_rx[win_idx*PRIO_W +: PRIO_W];
  assign win_len   = (int'(win_prio) > BURST_MAX) ? HDR_LEN_W'(BURST_MAX)
                                                  : HDR_LEN_W'(win_prio);
  assign head_byte = chan_data_out[grant_q*D_W +: D_W];
  assign accept    = host_valid_q & host_ready;

  // The pop and the register load of the same byte share one edge
  assign pop_fire         = accept & ((state_q == ST_HDR) | (remaining_q != '0));
  assign chan_commit_read = chan_active_q & {N_CHAN{pop_fire}};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    grant_d       = grant_q;
    len_d         = len_q;
    remaining_d   = remaining_q;
    host_data_d   = host_data_q;
    host_valid_d  = host_valid_q;
    host_last_d   = host_last_q;
    chan_active_d = chan_active_q;
`ifdef SERIAL_ARB_RR_FAIRNESS_EN
    rr_ptr_d      = rr_ptr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d       = ST_HDR;
          grant_d       = win_idx;
          len_d         = win_len;
          chan_active_d = N_CHAN'(1) << win_idx;
          host_data_d   = D_W'(build_header(win_len, win_idx));
          host_valid_d  = 1'b1;
          host_last_d   = 1'b0;
`ifdef SERIAL_ARB_RR_FAIRNESS_EN
          rr_ptr_d      = (win_idx == HDR_CHAN_W'(N_CHAN - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end

      ST_HDR: begin
        if (accept) begin
          state_d     = ST_DATA;
          host_data_d = head_byte;
          remaining_d = len_q - 1'b1;
          host_last_d = (len_q == HDR_LEN_W'(1));
        end
      end

      ST_DATA: begin
        if (accept) begin
          if (remaining_q != '0) begin
            host_data_d = head_byte;
            remaining_d = remaining_q - 1'b1;
            host_last_d = (remaining_q == HDR_LEN_W'(1));
          end else begin
            state_d       = ST_IDLE;
            host_valid_d  = 1'b0;
            host_last_d   = 1'b0;
            chan_active_d = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      len_q         <= '0;
      remaining_q   <= '0;
      host_data_q   <= '0;
      host_valid_q  <= 1'b0;
      host_last_q   <= 1'b0;
      chan_active_q <= '0;
`ifdef SERIAL_ARB_RR_FAIRNESS_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      len_q         <= len_d;
      remaining_q   <= remaining_d;
      host_data_q   <= host_data_d;
      host_valid_q  <= host_valid_d;
      host_last_q   <= host_last_d;
      chan_active_q <= chan_active_d;
`ifdef SERIAL_ARB_RR_FAIRNESS_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign host_data   = host_data_q;
  assign host_valid  = host_valid_q;
  assign host_last   = host_last_q;
  assign chan_active = chan_active_q;

endmodule

// File: tb/tb_serial_chan_arbiter.sv
// Bench for serial_chan_arbiter: directed scenarios plus random priorities and
// back-pressure, checked against a frame-level reference model.
module tb_serial_chan_arbiter;

  localparam int D_W       = 8;
  localparam int N_CHAN    = 8;
  localparam int PLEVELS   = 8;
  localparam int PRIO_W    = 3;
  localparam int BURST_MAX = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [N_CHAN*PRIO_W-1:0] chan_priority_rx = '0;
  logic [N_CHAN*D_W-1:0]    chan_data_out = '0;
  logic [N_CHAN-1:0]        chan_commit_read;
  logic [N_CHAN-1:0]        chan_active;
  logic [D_W-1:0]           host_data;
  logic                     host_valid;
  logic                     host_ready = 1'b0;
  logic                     host_last;

  serial_chan_arbiter #(
    .D_W             (D_W),
    .N_CHAN          (N_CHAN),
    .PRIORITY_LEVELS (PLEVELS),
    .BURST_MAX       (BURST_MAX)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .chan_priority_rx (chan_priority_rx),
    .chan_data_out    (chan_data_out),
    .chan_commit_read (chan_commit_read),
    .chan_active      (chan_active),
    .host_data        (host_data),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .host_last        (host_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Channel FIFOs modelled as endless deterministic byte streams
  int rd      [N_CHAN];
  int pop_cnt [N_CHAN];

  // Reference model: bytes still owed for the current frame
  logic [7:0] exp_q[$];
  bit         busy;
  int         exp_chan;
  int         frame_pos;
  int         rr_ptr;
  logic [N_CHAN*PRIO_W-1:0] prio_drv;

  logic [7:0] obs_bytes[$];
  logic [7:0] obs_hdr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] stream_byte(input int ch, input int k);
    return 8'((ch * 53 + k * 17 + 5) % 256);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N_CHAN; i++) chan_data_out[i*D_W +: D_W] = stream_byte(i, rd[i]);
  endtask

  task automatic set_prio(input int ch, input int p);
    prio_drv[ch*PRIO_W +: PRIO_W] = PRIO_W'(p);
  endtask

  // Winner = highest value; ties go to the first match scanning from the base
  task automatic arbitrate();
    int p[N_CHAN];
    int best, w, len, base;
    best = 0;
    for (int i = 0; i < N_CHAN; i++) begin
      p[i] = int'(prio_drv[i*PRIO_W +: PRIO_W]);
      if (p[i] > best) best = p[i];
    end
    if (best == 0) return;
`ifdef SERIAL_ARB_RR_FAIRNESS_EN
    base = rr_ptr;
`else
    base = 0;
`endif
    w = -1;
    for (int k = 0; k < N_CHAN; k++)
      if (w < 0 && p[(base + k) % N_CHAN] == best) w = (base + k) % N_CHAN;
    len = (best < BURST_MAX) ? best : BURST_MAX;
    exp_q.delete();
    exp_q.push_back(8'(len * 16 + w));
    for (int j = 0; j < len; j++) exp_q.push_back(stream_byte(w, rd[w] + j));
    busy      = 1'b1;
    exp_chan  = w;
    frame_pos = 0;
    rr_ptr    = (w + 1) % N_CHAN;
  endtask

  task automatic cycle(input bit rdy);
    logic [N_CHAN-1:0] exp_pop;
    logic [N_CHAN-1:0] pops_now;
    @(negedge clk);
    if (busy) begin
      check("valid", 32'(host_valid), 32'd1);
      check("data", 32'(host_data), 32'(exp_q[0]));
      check("last", 32'(host_last), 32'(exp_q.size() == 1));
      check("active", 32'(chan_active), 32'(1) << exp_chan);
    end else begin
      check("valid_idle", 32'(host_valid), 32'd0);
      check("active_idle", 32'(chan_active), 32'd0);
    end
    host_ready       = rdy;
    chan_priority_rx = prio_drv;
    #1;
    exp_pop = '0;
    if (busy && rdy && exp_q.size() > 1) exp_pop[exp_chan] = 1'b1;
    check("pop", 32'(chan_commit_read), 32'(exp_pop));
    pops_now = chan_commit_read;
    if (busy) begin
      if (rdy) begin
        obs_bytes.push_back(host_data);
        if (frame_pos == 0) obs_hdr.push_back(host_data);
        frame_pos++;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) busy = 1'b0;
      end
    end else begin
      arbitrate();
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CHAN; i++)
      if (pops_now[i]) begin
        rd[i]++;
        pop_cnt[i]++;
      end
    drive_data();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(host_valid), 32'd0);
    check({tag, "_last"}, 32'(host_last), 32'd0);
    check({tag, "_data"}, 32'(host_data), 32'd0);
    check({tag, "_active"}, 32'(chan_active), 32'd0);
    check({tag, "_pop"}, 32'(chan_commit_read), 32'd0);
  endtask

  task automatic do_reset();
    prio_drv         = '0;
    chan_priority_rx = '0;
    host_ready       = 1'b1;
    rst_n            = 1'b0;
    #1;
    check_outputs_zero("rst");
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_pop", 32'(chan_commit_read), 32'd0);
    end
    rst_n = 1'b1;
    busy  = 1'b0;
    exp_q.delete();
    rr_ptr = 0;
  endtask

  initial begin
    int cnt;
    int pops_before;
    for (int i = 0; i < N_CHAN; i++) begin
      rd[i]      = 0;
      pop_cnt[i] = 0;
    end
    busy     = 1'b0;
    rr_ptr   = 0;
    prio_drv = '0;
    drive_data();
    #1;
    do_reset();

    // Single channel, len 2
    obs_bytes.delete(); obs_hdr.delete();
    set_prio(3, 2);
    cycle(1'b1);
    prio_drv = '0;
    repeat (4) cycle(1'b1);
    check("t1_nbytes", 32'(obs_bytes.size()), 32'd3);
    if (obs_bytes.size() == 3) begin
      check("t1_hdr", 32'(obs_bytes[0]), 32'h23);
      check("t1_d0", 32'(obs_bytes[1]), 32'(stream_byte(3, 0)));
      check("t1_d1", 32'(obs_bytes[2]), 32'(stream_byte(3, 1)));
    end
    check("t1_pops", 32'(pop_cnt[3]), 32'd2);

    // Two channels, different priorities
    obs_bytes.delete(); obs_hdr.delete();
    set_prio(1, 7); set_prio(5, 3);
    cycle(1'b1);
    set_prio(1, 0);
    repeat (5) cycle(1'b1);
    cycle(1'b1);
    prio_drv = '0;
    repeat (5) cycle(1'b1);
    check("t2_nhdr", 32'(obs_hdr.size()), 32'd2);
    if (obs_hdr.size() == 2) begin
      check("t2_hdr0", 32'(obs_hdr[0]), 32'h41);
      check("t2_hdr1", 32'(obs_hdr[1]), 32'h35);
    end

    // Back-pressure in the middle of a data phase
    obs_bytes.delete(); obs_hdr.delete();
    set_prio(7, 4);
    cycle(1'b1);
    prio_drv = '0;
    cycle(1'b1);
    cycle(1'b1);
    pops_before = pop_cnt[7];
    repeat (5) cycle(1'b0);
    check("t4_stall_pops", 32'(pop_cnt[7]), 32'(pops_before));
    repeat (4) cycle(1'b1);
    check("t4_nbytes", 32'(obs_bytes.size()), 32'd5);
    if (obs_bytes.size() == 5) begin
      check("t4_hdr", 32'(obs_bytes[0]), 32'h47);
      for (int j = 0; j < 4; j++)
        check("t4_data", 32'(obs_bytes[1+j]), 32'(stream_byte(7, j)));
    end

    // Asynchronous reset in the middle of a 4-byte burst
    obs_hdr.delete();
    set_prio(0, 5);
    cycle(1'b1);
    prio_drv = '0;
    cycle(1'b1);
    cycle(1'b1);
    #2;
    pops_before = pop_cnt[0];
    do_reset();
    set_prio(4, 1);
    cycle(1'b1);
    prio_drv = '0;
    repeat (3) cycle(1'b1);
    check("t5_pops_after_rst", 32'(pop_cnt[0]), 32'(pops_before));
    check("t5_nhdr", 32'(obs_hdr.size()), 32'd2);
    if (obs_hdr.size() == 2) check("t5_fresh_hdr", 32'(obs_hdr[1]), 32'h14);

    // Tie between channels 2 and 6 over three frames
    do_reset();
    obs_hdr.delete();
    set_prio(2, 4); set_prio(6, 4);
    cnt = 0;
    while (!(obs_hdr.size() >= 3 && !busy) && cnt < 60) begin
      if (obs_hdr.size() >= 3) prio_drv = '0;
      cycle(1'b1);
      cnt++;
    end
    check("t3_done", 32'(cnt < 60), 32'd1);
    check("t3_nhdr", 32'(obs_hdr.size()), 32'd3);
    if (obs_hdr.size() == 3) begin
      check("t3_g0", 32'(obs_hdr[0][2:0]), 32'd2);
`ifdef SERIAL_ARB_RR_FAIRNESS_EN
      check("t3_g1", 32'(obs_hdr[1][2:0]), 32'd6);
`else
      check("t3_g1", 32'(obs_hdr[1][2:0]), 32'd2);
`endif
      check("t3_g2", 32'(obs_hdr[2][2:0]), 32'd2);
    end
    prio_drv = '0;
    cycle(1'b1);

    // No requests for 100 cycles
    obs_bytes.delete();
    cnt = 0;
    for (int i = 0; i < N_CHAN; i++) cnt += pop_cnt[i];
    repeat (100) cycle(1'($urandom_range(0, 1)));
    for (int i = 0; i < N_CHAN; i++) cnt -= pop_cnt[i];
    check("t6_no_pops", 32'(cnt), 32'd0);
    check("t6_no_bytes", 32'(obs_bytes.size()), 32'd0);

    // Random priorities and back-pressure
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N_CHAN; i++) begin
          if ($urandom_range(0, 1) == 0)      set_prio(i, 0);
          else if ($urandom_range(0, 2) == 0) set_prio(i, int'($urandom_range(1, 7)));
          else                                set_prio(i, 4);
        end
      end
      cycle(1'($urandom_range(0, 3) != 0));
    end
    prio_drv = '0;
    cnt = 0;
    while (busy && cnt < 50) begin
      cycle(1'b1);
      cnt++;
    end
    check("drain", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
